// File: rtl/alu_pkg.sv
// Shared opcode, funct3 and state encodings for the execute unit.
// Imported by alu_mdu and muldiv_unit.
package alu_pkg;

  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    LOAD   = 7'b0000011,
    S_TYPE = 7'b0100011,
    B_TYPE = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } instruction_type;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] M_FUNCT7 = 7'h01;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider on magnitudes.
// One step per cycle; done pulses one cycle after the last step.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic              done_q;
  logic              is_div;
  logic              take_hi;
  logic              neg_lo;
  logic              neg_hi;

  logic              signed_a;
  logic              signed_b;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  assign signed_a = !(funct3 == F3_MULHU || funct3 == F3_DIVU ||
                      funct3 == F3_REMU);
  assign signed_b = signed_a && (funct3 != F3_MULHSU);
  assign sa = signed_a && operand_a[XLEN-1];
  assign sb = signed_b && operand_b[XLEN-1];
  assign mag_a = sa ? -operand_a : operand_a;
  assign mag_b = sb ? -operand_b : operand_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} +
                   (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Shifted partial remainder needs XLEN+1 bits before the trial subtract.
  assign trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_next = trial[XLEN]
                  ? {acc[2*XLEN-2:0], 1'b0}
                  : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done_q  <= 1'b0;
      is_div  <= 1'b0;
      take_hi <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc     <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
        opnd    <= funct3[2] ? mag_b : mag_a;
        cnt     <= '0;
        run     <= 1'b1;
        is_div  <= funct3[2];
        take_hi <= funct3[2] ? funct3[1] : (funct3 != F3_MUL);
        neg_lo  <= sa ^ sb;
        neg_hi  <= funct3[2] ? sa : (sa ^ sb);
      end else if (run) begin
        acc <= is_div ? div_next : mul_next;
        if (cnt == LAST) begin
          run    <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign prod = neg_lo ? -acc : acc;
  assign quo  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    if (is_div) result = take_hi ? rem : quo;
    else result = take_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign busy = run;
  assign done = done_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute unit: single-cycle RV32I ALU/branch/address ops plus
// iterative RV32M multiply/divide behind valid/ready handshakes.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op_code,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state;
  state_t state_nx;

  logic              accept;
  logic              is_m;
  logic              special;
  logic              start;
  logic [XLEN-1:0]   base_res;
  logic [XLEN-1:0]   spec_res;
  logic [XLEN-1:0]   result_q;
  logic              mdu_busy;
  logic              mdu_done;
  logic [XLEN-1:0]   mdu_res;

  logic              div0;
  logic              ovf;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_m     = (op_code == R_TYPE) && (funct7 == M_FUNCT7);
  assign div0     = (operand_b == '0);
  assign ovf      = !funct3[0] && (operand_a == MIN) && (&operand_b);
  assign special  = is_m && funct3[2] && (div0 || ovf);
  assign start    = accept && is_m && !special;

  always_comb begin
    spec_res = '0;
    if (div0) spec_res = funct3[1] ? operand_a : '1;
    else if (ovf) spec_res = funct3[1] ? '0 : MIN;
  end

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    add_r;
  logic [XLEN-1:0]    sub_r;
  logic [XLEN-1:0]    srl_r;
  logic [XLEN-1:0]    sra_r;
  logic               lt;
  logic               ltu;

  assign shamt = operand_b[SHAMT_W-1:0];
  assign add_r = operand_a + operand_b;
  assign sub_r = operand_a - operand_b;
  assign srl_r = operand_a >> shamt;
  assign sra_r = $signed(operand_a) >>> shamt;
  assign lt    = $signed(operand_a) < $signed(operand_b);
  assign ltu   = operand_a < operand_b;

  always_comb begin
    base_res = '0;
    unique case (op_code)
      R_TYPE, I_TYPE: begin
        unique case (funct3)
          F3_ADD:  base_res = (op_code == R_TYPE && funct7[5])
                            ? sub_r : add_r;
          F3_SLL:  base_res = operand_a << shamt;
          F3_SLT:  base_res = {{(XLEN-1){1'b0}}, lt};
          F3_SLTU: base_res = {{(XLEN-1){1'b0}}, ltu};
          F3_XOR:  base_res = operand_a ^ operand_b;
          F3_SR: begin
            if (op_code == R_TYPE) base_res = funct7[5] ? sra_r : srl_r;
            else base_res = operand_b[10] ? sra_r : srl_r;
          end
          F3_OR:   base_res = operand_a | operand_b;
          F3_AND:  base_res = operand_a & operand_b;
          default: base_res = '0;
        endcase
      end
      B_TYPE: begin
        unique case (funct3)
          F3_BEQ:  base_res = {XLEN{operand_a == operand_b}};
          F3_BNE:  base_res = {XLEN{operand_a != operand_b}};
          F3_BLT:  base_res = {XLEN{lt}};
          F3_BGE:  base_res = {XLEN{!lt}};
          F3_BLTU: base_res = {XLEN{ltu}};
          F3_BGEU: base_res = {XLEN{!ltu}};
          default: base_res = '0;
        endcase
      end
      LOAD, S_TYPE, JAL, AUIPC: base_res = add_r;
      JALR:    base_res = {add_r[XLEN-1:1], 1'b0};
      LUI:     base_res = operand_b;
      default: base_res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (!is_m || special) state_nx = DONE;
          else state_nx = funct3[2] ? DIV : MUL;
        end else if (state == DONE && out_ready) begin
          state_nx = IDLE;
        end
      end
      MUL, DIV: if (mdu_done) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (accept && !start) result_q <= is_m ? spec_res : base_res;
      else if (mdu_done) result_q <= mdu_res;
    end
  end

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (mdu_busy),
    .done      (mdu_done),
    .result    (mdu_res)
  );

  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign busy      = mdu_busy;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: driver queues expected results,
// a negedge monitor pops and checks value and latency on each transfer.
module tb_alu_mdu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  alu_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .funct3    (funct3),
    .funct7    (funct7),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;
  localparam logic [6:0] OP_B = 7'h63;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_BAD = 7'h7F;
  localparam int ITER = 33;

  typedef struct {
    string       nm;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%h expected=none", result);
      end else begin
        exp_t it;
        it = q.pop_front();
        chk(it.nm, result, it.exp);
        if (it.lat >= 0)
          chk({it.nm, "_lat"}, 32'(cyc - it.acc), 32'(it.lat));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input string nm, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input bit push, output int stalls);
    in_valid  = 1'b1;
    op_code   = op;
    funct3    = f3;
    funct7    = f7;
    operand_a = a;
    operand_b = b;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
    end else if (push) begin
      exp_t it;
      it.nm  = nm;
      it.exp = exp;
      it.lat = lat;
      it.acc = cyc + 1;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int st;
    int nb;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_code = '0;
    funct3 = '0;
    funct7 = '0;
    operand_a = '0;
    operand_b = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;

    issue("add", OP_R, 3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 0, 1, st);
    issue("sub", OP_R, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 1, st);
    chk("sub_b2b_stalls", 32'(st), 32'd0);
    issue("sll33", OP_R, 3'd1, 7'h00, 32'd3, 32'd33, 32'd6, 0, 1, st);
    issue("srai", OP_I, 3'd5, 7'h00, 32'h80000000, 32'h401,
          32'hC0000000, 0, 1, st);
    issue("srli", OP_I, 3'd5, 7'h00, 32'h80000000, 32'h001,
          32'h40000000, 0, 1, st);
    issue("jalr", OP_JALR, 3'd0, 7'h00, 32'h101, 32'h0, 32'h100, 0, 1, st);
    issue("lui", OP_LUI, 3'd0, 7'h00, 32'h5, 32'h12345000,
          32'h12345000, 0, 1, st);
    issue("bad_op", OP_BAD, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 0, 1, st);
    issue("bad_br", OP_B, 3'd2, 7'h00, 32'd5, 32'd5, 32'd0, 0, 1, st);
    issue("sltiu", OP_I, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 0, 1, st);
    issue("bge_f", OP_B, 3'd5, 7'h00, 32'hFFFFFFFB, 32'd3, 32'd0, 0, 1, st);
    drain();

    issue("mulh", OP_R, 3'd1, 7'h01, 32'h80000000, 32'd2,
          32'hFFFFFFFF, ITER, 1, st);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (out_valid) break;
    end
    chk("mulh_busy_cycles", 32'(nb), 32'd32);
    @(posedge clk);
    #1;
    issue("mulhu", OP_R, 3'd3, 7'h01, 32'h80000000, 32'd2,
          32'd1, ITER, 1, st);
    issue("mul", OP_R, 3'd0, 7'h01, 32'hFFFFFFFD, 32'd7,
          32'hFFFFFFEB, ITER, 1, st);
    issue("mulhsu", OP_R, 3'd2, 7'h01, 32'hFFFFFFFF, 32'd2,
          32'hFFFFFFFF, ITER, 1, st);
    issue("div", OP_R, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFD, ITER, 1, st);
    issue("rem", OP_R, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, ITER, 1, st);
    issue("divu", OP_R, 3'd5, 7'h01, 32'd100, 32'd7, 32'd14, ITER, 1, st);
    issue("remu", OP_R, 3'd7, 7'h01, 32'd100, 32'd7, 32'd2, ITER, 1, st);
    issue("divu_by0", OP_R, 3'd5, 7'h01, 32'h80000000, 32'd0,
          32'hFFFFFFFF, 0, 1, st);
    issue("rem_ovf", OP_R, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF,
          32'd0, 0, 1, st);
    issue("div_ovf", OP_R, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF,
          32'h80000000, 0, 1, st);
    drain();

    out_ready = 1'b0;
    issue("blt_bp", OP_B, 3'd4, 7'h00, 32'hFFFFFFFB, 32'd3,
          32'hFFFFFFFF, -1, 1, st);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'hFFFFFFFF);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    issue("div_rst", OP_R, 3'd4, 7'h01, 32'd100, 32'd7, 32'd0, 0, 0, st);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue("add_post", OP_R, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 0, 1, st);
    drain();
    repeat (40) @(negedge clk);
    chk("no_stray_output", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
